// File: rtl/gshare_bp_if.sv
// Fetch/execute-side bundle for the gshare branch predictor.
// master: pipeline side (drives fetch PC and resolved-branch updates).
// slave:  predictor side (returns prediction, BTB target and perf counters).
interface gshare_bp_if #(
  parameter int IDX_W = 6
);
  logic             pc_f_dummy_unused;
  logic [31:0]      pc_f;
  logic             pred_taken_f;
  logic [IDX_W-1:0] pred_index_f;
  logic [31:0]      pred_target_f;
  logic             pred_target_valid_f;
  logic             upd_valid_e;
  logic             upd_taken_e;
  logic             upd_pred_taken_e;
  logic [IDX_W-1:0] upd_index_e;
  logic [31:0]      upd_pc_e;
  logic [31:0]      upd_target_e;
  logic [31:0]      branch_count;
  logic [31:0]      mispredict_count;

  modport master (
    output pc_f, upd_valid_e, upd_taken_e, upd_pred_taken_e,
           upd_index_e, upd_pc_e, upd_target_e,
    input  pred_taken_f, pred_index_f, pred_target_f, pred_target_valid_f,
           branch_count, mispredict_count
  );

  modport slave (
    input  pc_f, upd_valid_e, upd_taken_e, upd_pred_taken_e,
           upd_index_e, upd_pc_e, upd_target_e,
    output pred_taken_f, pred_index_f, pred_target_f, pred_target_valid_f,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/gshare_branch_predictor.sv
// gshare dynamic branch predictor: PHT of saturating counters indexed by
// pc[IDX_W+1:2] XOR global history, trained non-speculatively at resolution.
// Optional direct-mapped BTB enabled by defining the macro BP_BTB_EN.
module gshare_branch_predictor #(
  parameter int ENTRIES     = 64,
  parameter int GHR_BITS    = 6,
  parameter int CTR_BITS    = 2,
  parameter int BTB_ENTRIES = 16
) (
  input logic        clk_c,
  input logic        rst_c,
  gshare_bp_if.slave bp
);

  localparam int IDX_W = $clog2(ENTRIES);
  // Storage width for history; a 1-bit dummy when history is disabled.
  localparam int GHR_W = (GHR_BITS > 0) ? GHR_BITS : 1;
  localparam logic [CTR_BITS-1:0] CTR_MAX     = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_ZERO    = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0] CTR_ONE     = CTR_BITS'(32'd1);
  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'((32'd1 << (CTR_BITS - 1)) - 32'd1);

  logic [CTR_BITS-1:0] pht_r [ENTRIES];
  logic [GHR_W-1:0]    ghr_r;
  logic [31:0]         branch_count_r;
  logic [31:0]         mispredict_count_r;

  logic [IDX_W-1:0]    ghr_ext;
  logic [IDX_W-1:0]    lookup_index;
  logic [CTR_BITS-1:0] ctr_cur;
  logic [CTR_BITS-1:0] ctr_next;
  logic [GHR_W:0]      ghr_shift;
  logic [GHR_W-1:0]    ghr_next;

  // Zero-extend the history to index width (all zero for the bimodal case).
  always_comb begin
    ghr_ext = {IDX_W{1'b0}};
    if (GHR_BITS > 0) begin
      ghr_ext[GHR_W-1:0] = ghr_r;
    end else begin
      ghr_ext = {IDX_W{1'b0}};
    end
  end

  // Combinational prediction from the pre-update state.
  always_comb begin
    lookup_index    = bp.pc_f[IDX_W+1:2] ^ ghr_ext;
    bp.pred_index_f = lookup_index;
    bp.pred_taken_f = pht_r[lookup_index][CTR_BITS-1];
  end

  // Saturating next value for the counter being trained.
  always_comb begin
    ctr_cur  = pht_r[bp.upd_index_e];
    ctr_next = ctr_cur;
    if (bp.upd_taken_e) begin
      if (ctr_cur == CTR_MAX) begin
        ctr_next = ctr_cur;
      end else begin
        ctr_next = ctr_cur + CTR_ONE;
      end
    end else begin
      if (ctr_cur == CTR_ZERO) begin
        ctr_next = ctr_cur;
      end else begin
        ctr_next = ctr_cur - CTR_ONE;
      end
    end
  end

  // Next global history: shift in the resolved outcome, drop the oldest bit.
  always_comb begin
    ghr_shift = {ghr_r, bp.upd_taken_e};
    if (GHR_BITS > 0) begin
      ghr_next = ghr_shift[GHR_W-1:0];
    end else begin
      ghr_next = {GHR_W{1'b0}};
    end
  end

  // PHT training; reset wins over a simultaneous update.
  always_ff @(posedge clk_c) begin
    if (rst_c) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht_r[i] <= CTR_WEAK_NT;
      end
    end else if (bp.upd_valid_e) begin
      pht_r[bp.upd_index_e] <= ctr_next;
    end
  end

  // Global history register, updated only at branch resolution.
  always_ff @(posedge clk_c) begin
    if (rst_c) begin
      ghr_r <= {GHR_W{1'b0}};
    end else if (bp.upd_valid_e) begin
      ghr_r <= ghr_next;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk_c) begin
    if (rst_c) begin
      branch_count_r     <= 32'd0;
      mispredict_count_r <= 32'd0;
    end else if (bp.upd_valid_e) begin
      if (branch_count_r != 32'hFFFF_FFFF) begin
        branch_count_r <= branch_count_r + 32'd1;
      end
      if ((bp.upd_taken_e != bp.upd_pred_taken_e) &&
          (mispredict_count_r != 32'hFFFF_FFFF)) begin
        mispredict_count_r <= mispredict_count_r + 32'd1;
      end
    end
  end

  assign bp.branch_count     = branch_count_r;
  assign bp.mispredict_count = mispredict_count_r;

`ifdef BP_BTB_EN
  localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W     = 30 - BTB_IDX_W;

  logic              btb_valid_r  [BTB_ENTRIES];
  logic [TAG_W-1:0]  btb_tag_r    [BTB_ENTRIES];
  logic [31:0]       btb_target_r [BTB_ENTRIES];
  logic [BTB_IDX_W-1:0] btb_rd_idx;
  logic [BTB_IDX_W-1:0] btb_wr_idx;
  logic              btb_write;

  // BTB lookup against the pre-write contents.
  always_comb begin
    btb_rd_idx = bp.pc_f[BTB_IDX_W+1:2];
    btb_wr_idx = bp.upd_pc_e[BTB_IDX_W+1:2];
    btb_write  = bp.upd_valid_e & bp.upd_taken_e;
    if (btb_valid_r[btb_rd_idx] &&
        (btb_tag_r[btb_rd_idx] == bp.pc_f[31:BTB_IDX_W+2])) begin
      bp.pred_target_valid_f = 1'b1;
      bp.pred_target_f       = btb_target_r[btb_rd_idx];
    end else begin
      bp.pred_target_valid_f = 1'b0;
      bp.pred_target_f       = 32'd0;
    end
  end

  // BTB valid bits: cleared on reset, set by taken branches.
  always_ff @(posedge clk_c) begin
    if (rst_c) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid_r[i] <= 1'b0;
      end
    end else if (btb_write) begin
      btb_valid_r[btb_wr_idx] <= 1'b1;
    end
  end

  // BTB tag/target payload; contents are qualified by the valid bit.
  always_ff @(posedge clk_c) begin
    if (!rst_c && btb_write) begin
      btb_tag_r[btb_wr_idx]    <= bp.upd_pc_e[31:BTB_IDX_W+2];
      btb_target_r[btb_wr_idx] <= bp.upd_target_e;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bp.pc_f[1:0], bp.upd_pc_e[1:0], ghr_r};
`else
  assign bp.pred_target_f       = 32'd0;
  assign bp.pred_target_valid_f = 1'b0;

  // Branch PC/target only feed the BTB, which is absent in this build.
  logic unused_bits;
  assign unused_bits = ^{bp.pc_f[31:IDX_W+2], bp.pc_f[1:0], bp.upd_pc_e,
                         bp.upd_target_e, ghr_r, 32'(BTB_ENTRIES)};
`endif

endmodule
